fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-bit byte FIFO. Pops one byte at a time whenever the FIFO reports non-empty and serializes it as an asynchronous UART frame. Frame format is 1 start bit, 8 data bits LSB-first, an optional even-parity bit and 1 stop bit. Connects directly to the FIFO's read_enb, empty and dataout; the serial line is the block's only external output.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal values are 2 and above; the bit counter is $clog2(CLKS_PER_BIT) wide.
PARITY_EN, 0, 1 inserts an even-parity bit between D7 and stop.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
tx_en  input  1  when high, new frames may start; when low, the current frame completes and no new pop is issued.
empty  input  1  FIFO empty flag.
dataout  input  8  FIFO read data; valid from the edge that consumes read_enb.
read_enb  output  1  FIFO pop strobe; high for exactly one cycle per byte.
tx  output  1  serial line; idles high.
busy  output  1  high from the pop through the end of the stop bit.
frame_done  output  1  single-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, tx=1, read_enb=0, busy=0, frame_done=0, shift register=0, counters=0.
- Reset takes priority over all other inputs. Reset mid-frame aborts the frame: tx=1 from the next edge, and the popped byte is discarded.
- FIFO contract:
  - The FIFO samples read_enb on the rising edge.
  - dataout is valid the cycle after read_enb is high.
  - read_enb is never asserted in a cycle where empty is sampled high.
- State machine; read_enb, busy and frame_done are decoded from the state register and counters:
  - IDLE: tx=1, busy=0. If tx_en && !empty, go to POP.
  - POP: read_enb=1, busy=1, tx=1. Lasts 1 cycle, then WAIT.
  - WAIT: tx=1. Lasts 1 cycle. On the exiting edge, latch dataout into the shift register, compute parity = ^dataout, then go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]. Each bit lasts CLKS_PER_BIT cycles; shift right after each bit. After 8 bits go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: tx=parity (even: total count of ones across data plus parity is even). Lasts CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 in its final cycle. Then IDLE, unconditionally.
- Bit timing counter: counts 0..CLKS_PER_BIT-1 and resets on every state/bit change.
- Frame length in START..STOP is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- Back-to-back frames: minimum gap between a stop bit's end and the next start bit is 3 cycles of tx=1 (IDLE, POP, WAIT).
- empty and dataout are ignored outside IDLE and WAIT. A FIFO refill during a frame has no effect until IDLE.
- tx_en falling mid-frame: the frame completes normally. tx_en is sampled only in IDLE.
- tx_en high with empty high: stay in IDLE indefinitely; read_enb stays 0.

Test Plan:
1. Hold reset high for 2 cycles with empty=0 and tx_en=1 -> tx=1, read_enb=0, busy=0 throughout reset; first read_enb pulse occurs on the 2nd cycle after reset falls (IDLE, then POP).
2. CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds one byte 8'h03, then empty=1:
   - tx sequence is 0 for 4 cycles, then data bits 1,1,0,0,0,0,0,0 for 4 cycles each, then 1 for 4 cycles.
   - frame_done pulses once, in the last stop-bit cycle.
   - Exactly one read_enb pulse; tx stays 1 afterwards.
3. FIFO preloaded with 6 bytes of 8'h03 (the FIFO bench's fill pattern):
   - Exactly 6 read_enb pulses and 6 frames.
   - Stop end to next start gap is exactly 3 cycles.
   - Last frame ends with busy=0 once empty=1.
4. PARITY_EN=1, byte 8'hA5 -> parity bit 0; byte 8'h07 -> parity bit 1; frame length 44 cycles.
5. Assert reset during data bit 3 of a frame -> tx=1 on the next edge; state returns to IDLE; the byte is lost; the next frame sends the next FIFO byte correctly.
6. tx_en dropped mid-frame with FIFO non-empty -> current frame completes; no further read_enb while tx_en=0; raising tx_en resumes pops.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and sends each byte as a UART frame (start, 8 data LSB-first, optional even parity, stop).
// Latency: start bit begins 3 cycles after the idle cycle that sees a non-empty FIFO (IDLE, POP, WAIT); a frame is 10 or 11 bit times.
// Backpressure: one byte in flight; a pop is issued only from IDLE with tx_en high and empty low, never mid-frame.
// Ports: clk/reset (synchronous, active-high); tx_en gates new frames; empty/dataout/read_enb form the FIFO
//        read side; tx is the serial line; busy spans pop through stop; frame_done marks the last stop-bit cycle.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic       empty,
    input  logic [7:0] dataout,
    output logic       read_enb,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic             bit_end;
    logic             serial_state;

    assign bit_end      = (cnt_q == CNT_LAST);
    assign serial_state = (state_q == S_START) || (state_q == S_DATA) ||
                          (state_q == S_PARITY) || (state_q == S_STOP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and decoded outputs
    always_comb begin
        state_d    = state_q;
        read_enb   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        tx         = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                // tx_en is only looked at here, so dropping it mid-frame lets the frame finish.
                if (tx_en && !empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                read_enb = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx = shift_q[0];
                if (bit_end && (bit_idx_q == 3'd7)) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                tx = parity_q;
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                frame_done = bit_end;
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bit timer, bit index, shift register and parity
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
        end else begin
            // Every bit boundary coincides with bit_end, so wrapping here also restarts the
            // timer on each state change inside the frame.
            if (serial_state && !bit_end) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end

            // dataout is valid in WAIT, the cycle after the pop strobe.
            if (state_q == S_WAIT) begin
                shift_q   <= dataout;
                parity_q  <= ^dataout;
                bit_idx_q <= '0;
            end else if ((state_q == S_DATA) && bit_end) begin
                shift_q   <= shift_q >> 1;
                bit_idx_q <= bit_idx_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives two fifo_uart_tx instances (no parity / even parity) from queue-based FIFO models
// and compares every output cycle against waveforms computed from the frame format.
module tb_fifo_uart_tx;

    localparam int C   = 4;
    localparam int FL0 = 3 + 10 * C;   // idle + pop + wait + frame, no parity
    localparam int FL1 = 3 + 11 * C;   // same with parity bit

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic       empty0, empty1;
    logic [7:0] dout0, dout1;
    logic       re0, re1, tx0, tx1, busy0, busy1, fd0, fd1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    // per-cycle trace entries are {busy, frame_done, read_enb, tx}
    logic [3:0] tr0[$];
    logic [3:0] tr1[$];
    logic [3:0] exp0[$];
    logic [3:0] exp1[$];
    logic [7:0] none[$];

    int tests     = 0;
    int failed    = 0;
    int underflow = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset(reset), .tx_en(tx_en), .empty(empty0), .dataout(dout0),
        .read_enb(re0), .tx(tx0), .busy(busy0), .frame_done(fd0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(reset), .tx_en(tx_en), .empty(empty1), .dataout(dout1),
        .read_enb(re1), .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    // Record the current cycle, cross one edge, then apply the FIFO pops seen on that edge.
    task automatic step();
        logic r0, r1;
        tr0.push_back({busy0, fd0, re0, tx0});
        tr1.push_back({busy1, fd1, re1, tx1});
        r0 = re0;
        r1 = re1;
        @(posedge clk);
        #1;
        if (r0 === 1'b1) begin
            if (q0.size() > 0) dout0 = q0.pop_front();
            else underflow++;
        end
        if (r1 === 1'b1) begin
            if (q1.size() > 0) dout1 = q1.pop_front();
            else underflow++;
        end
        empty0 = (q0.size() == 0);
        empty1 = (q1.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_traces();
        tr0 = {};
        tr1 = {};
    endtask

    // Expected waveform for an idle transmitter fed these bytes back to back, padded with idle to len.
    function automatic void build_exp(input logic [7:0] bytes[$], input bit par, input int len,
                                      output logic [3:0] e[$]);
        int   ones;
        int   nbits;
        logic b;
        e = {};
        nbits = par ? 11 : 10;
        foreach (bytes[n]) begin
            e.push_back(4'b0001);
            e.push_back(4'b1011);
            e.push_back(4'b1001);
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(bytes[n][i]);
            for (int j = 0; j < nbits; j++) begin
                if (j == 0)                b = 1'b0;
                else if (j <= 8)           b = bytes[n][j-1];
                else if (par && (j == 9))  b = ((ones % 2) == 1);
                else                       b = 1'b1;
                for (int k = 0; k < C; k++)
                    e.push_back({1'b1, ((j == nbits - 1) && (k == C - 1)), 1'b0, b});
            end
        end
        while (e.size() < len) e.push_back(4'b0001);
    endfunction

    function automatic int first_diff(input logic [3:0] a[$], input logic [3:0] b[$]);
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        return -1;
    endfunction

    function automatic int count_bit(input logic [3:0] a[$], input int k);
        int n = 0;
        foreach (a[i]) if (a[i][k] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        logic [7:0] bq[$];
        int d;
        reset = 1'b1;
        tx_en = 1'b1;
        q0.push_back(8'h5C);
        empty0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if ({tx0, re0, busy0, fd0, tx1, re1, busy1, fd1} !== 8'b1000_1000) begin
                failed++;
                $display("FAIL reset_outputs cycle %0d got %b want 10001000", i,
                         {tx0, re0, busy0, fd0, tx1, re1, busy1, fd1});
            end
        end
        reset = 1'b0;
        clear_traces();
        run(FL0 + 5);
        tests++;
        if (tr0[0][1] !== 1'b0 || tr0[1][1] !== 1'b1) begin
            failed++;
            $display("FAIL first_pop read_enb cycles 0,1 got %b%b want 01", tr0[0][1], tr0[1][1]);
        end
        bq.push_back(8'h5C);
        build_exp(bq, 1'b0, FL0 + 5, exp0);
        d = first_diff(tr0, exp0);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL post_reset_frame cycle %0d got %b want %b", d, tr0[d], exp0[d]);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] bq[$];
        int d;
        q0.push_back(8'h03);
        empty0 = 1'b0;
        clear_traces();
        run(FL0 + 10);
        bq.push_back(8'h03);
        build_exp(bq, 1'b0, FL0 + 10, exp0);
        build_exp(none, 1'b0, FL0 + 10, exp1);
        d = first_diff(tr0, exp0);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL single_frame cycle %0d got %b want %b", d, tr0[d], exp0[d]);
        end
        d = first_diff(tr1, exp1);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL single_other_idle cycle %0d got %b want %b", d, tr1[d], exp1[d]);
        end
        tests++;
        if (count_bit(tr0, 1) !== 1) begin
            failed++;
            $display("FAIL single_pop_count got %0d want 1", count_bit(tr0, 1));
        end
        tests++;
        if (count_bit(tr0, 2) !== 1 || tr0[FL0 - 1][2] !== 1'b1) begin
            failed++;
            $display("FAIL single_frame_done count %0d at_last_stop %b want 1 1",
                     count_bit(tr0, 2), tr0[FL0 - 1][2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bq[$];
        int d, bad_gaps, len;
        len = 6 * FL0 + 5;
        for (int i = 0; i < 6; i++) begin
            q0.push_back(8'h03);
            bq.push_back(8'h03);
        end
        empty0 = 1'b0;
        clear_traces();
        run(len);
        build_exp(bq, 1'b0, len, exp0);
        d = first_diff(tr0, exp0);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL b2b_waveform cycle %0d got %b want %b", d, tr0[d], exp0[d]);
        end
        tests++;
        if (count_bit(tr0, 1) !== 6 || count_bit(tr0, 2) !== 6) begin
            failed++;
            $display("FAIL b2b_counts pops %0d frames %0d want 6 6", count_bit(tr0, 1), count_bit(tr0, 2));
        end
        bad_gaps = 0;
        for (int i = 0; i < tr0.size(); i++) begin
            if (tr0[i][2] === 1'b1) begin
                for (int j = i + 1; j < tr0.size(); j++) begin
                    if (tr0[j][0] === 1'b0) begin
                        if (j - i - 1 != 3) bad_gaps++;
                        break;
                    end
                end
            end
        end
        tests++;
        if (bad_gaps != 0) begin
            failed++;
            $display("FAIL b2b_gap bad gaps %0d want 0", bad_gaps);
        end
        tests++;
        if (busy0 !== 1'b0 || empty0 !== 1'b1) begin
            failed++;
            $display("FAIL b2b_final_busy got busy %b empty %b want 0 1", busy0, empty0);
        end
    endtask

    task automatic test_parity();
        logic [7:0] bq[$];
        int d, s, f, len;
        len = 2 * FL1 + 5;
        q1.push_back(8'hA5);
        q1.push_back(8'h07);
        bq = q1;
        empty1 = 1'b0;
        clear_traces();
        run(len);
        build_exp(bq, 1'b1, len, exp1);
        d = first_diff(tr1, exp1);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL parity_waveform cycle %0d got %b want %b", d, tr1[d], exp1[d]);
        end
        s = 3;
        tests++;
        if (tr1[s + 9 * C][0] !== 1'b0 || tr1[FL1 + s + 9 * C][0] !== 1'b1) begin
            failed++;
            $display("FAIL parity_bits A5 %b 07 %b want 0 1", tr1[s + 9 * C][0], tr1[FL1 + s + 9 * C][0]);
        end
        f = -1;
        for (int i = 0; i < tr1.size(); i++) if (f < 0 && tr1[i][2] === 1'b1) f = i;
        tests++;
        if (f - s + 1 != 11 * C) begin
            failed++;
            $display("FAIL parity_frame_len got %0d want %0d", f - s + 1, 11 * C);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] bq[$];
        logic [7:0] b0, b1;
        int d;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        q0.push_back(b0);
        q0.push_back(b1);
        empty0 = 1'b0;
        clear_traces();
        run(3 + 4 * C + 2);       // into data bit 3
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || q0.size() != 1) begin
            failed++;
            $display("FAIL reset_abort tx %b busy %b fifo_left %0d want 1 0 1", tx0, busy0, q0.size());
        end
        clear_traces();
        run(FL0 + 5);
        bq.push_back(b1);
        build_exp(bq, 1'b0, FL0 + 5, exp0);
        d = first_diff(tr0, exp0);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL reset_recover cycle %0d got %b want %b", d, tr0[d], exp0[d]);
        end
    endtask

    task automatic test_tx_en_gate();
        logic [7:0] bq[$];
        logic [7:0] rest[$];
        int d;
        for (int i = 0; i < 3; i++) q0.push_back(8'($urandom));
        bq.push_back(q0[0]);
        rest.push_back(q0[1]);
        rest.push_back(q0[2]);
        empty0 = 1'b0;
        clear_traces();
        run(10);
        tx_en = 1'b0;
        run(FL0 + 10);
        build_exp(bq, 1'b0, FL0 + 20, exp0);
        d = first_diff(tr0, exp0);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL gate_finish_frame cycle %0d got %b want %b", d, tr0[d], exp0[d]);
        end
        tests++;
        if (count_bit(tr0, 1) != 1 || q0.size() != 2) begin
            failed++;
            $display("FAIL gate_no_pop pops %0d fifo_left %0d want 1 2", count_bit(tr0, 1), q0.size());
        end
        tx_en = 1'b1;
        clear_traces();
        run(2 * FL0 + 5);
        build_exp(rest, 1'b0, 2 * FL0 + 5, exp0);
        d = first_diff(tr0, exp0);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL gate_resume cycle %0d got %b want %b", d, tr0[d], exp0[d]);
        end
    endtask

    task automatic test_random();
        logic [7:0] bq[$];
        int d, n, len;
        bit sel;
        for (int it = 0; it < 6; it++) begin
            sel = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 4);
            bq  = {};
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            len = n * (sel ? FL1 : FL0) + 4;
            if (sel) begin q1 = bq; empty1 = 1'b0; end
            else     begin q0 = bq; empty0 = 1'b0; end
            clear_traces();
            run(len);
            build_exp(sel ? none : bq, 1'b0, len, exp0);
            build_exp(sel ? bq : none, 1'b1, len, exp1);
            d = sel ? first_diff(tr1, exp1) : first_diff(tr0, exp0);
            tests++;
            if (d >= 0) begin
                failed++;
                $display("FAIL random_%0d dut%0d cycle %0d got %b want %b", it, sel, d,
                         sel ? tr1[d] : tr0[d], sel ? exp1[d] : exp0[d]);
            end
            d = sel ? first_diff(tr0, exp0) : first_diff(tr1, exp1);
            tests++;
            if (d >= 0) begin
                failed++;
                $display("FAIL random_%0d idle_dut cycle %0d", it, d);
            end
        end
        tests++;
        if (underflow != 0) begin
            failed++;
            $display("FAIL pop_while_empty got %0d want 0", underflow);
        end
    endtask

    initial begin
        reset  = 1'b1;
        tx_en  = 1'b0;
        empty0 = 1'b1;
        empty1 = 1'b1;
        dout0  = 8'h00;
        dout1  = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_parity();
        test_reset_midframe();
        test_tx_en_gate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish within 2 ms");
        $fatal(1, "timeout");
    end

endmodule
